// File: rtl/stream_capture_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : stream_capture_ctrl                                                |
// | Purpose : Frame sequencer gating an AXI-Stream source into stream_buffer.    |
// |           Optional level trigger enabled by STREAM_CAPTURE_TRIGGER_EN.       |
// | Rev     : 1.0  initial release                                               |
// +-----------------------------------------------------------------------------+
module stream_capture_ctrl #(
  parameter int DW = 16,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce,
  input  logic [DW-1:0] tdata_s,
  input  logic          tvalid_s,
  output logic          tready_s,
  output logic [DW-1:0] tdata_m,
  output logic          tvalid_m,
  input  logic          tready_m,
  output logic          tuser_m,
  output logic          tlast_m,
  input  logic [LW-1:0] frame_len_i,
  input  logic          arm_i,
  input  logic          continuous_i,
  input  logic          release_i,
  input  logic          abort_i,
`ifdef STREAM_CAPTURE_TRIGGER_EN
  input  logic [DW-1:0] trig_level_i,
`endif
  output logic          busy_o,
  output logic [1:0]    state_o,
  output logic          frame_done_o,
  output logic [15:0]   frame_cnt_o
);

  localparam logic [1:0]    c_idle    = 2'd0;
  localparam logic [1:0]    c_capture = 2'd2;
  localparam logic [1:0]    c_hold    = 2'd3;
  localparam logic [LW-1:0] c_len_one = LW'(1);
`ifdef STREAM_CAPTURE_TRIGGER_EN
  localparam logic [1:0]    c_wait_trig = 2'd1;
  localparam logic [1:0]    c_arm_state = c_wait_trig;
  localparam logic [DW-1:0] c_most_neg  = {1'b1, {(DW-1){1'b0}}};
`else
  localparam logic [1:0]    c_arm_state = c_capture;
`endif

  logic [1:0]    r_state, w_state_nxt;
  logic [LW-1:0] r_idx, w_idx_nxt;
  logic [LW-1:0] r_len, w_len_nxt;
  logic [15:0]   r_frame_cnt, w_frame_cnt_nxt;
  logic          r_frame_done, w_frame_done_nxt;
  logic          w_fire, w_pass_state, w_last, w_hs;

`ifdef STREAM_CAPTURE_TRIGGER_EN
  logic [DW-1:0] r_prev, w_prev_nxt;
  // The rising-edge sample itself becomes idx 0 of the frame.
  assign w_fire = (r_state == c_wait_trig) && tvalid_s &&
                  ($signed(r_prev) < $signed(trig_level_i)) &&
                  ($signed(trig_level_i) <= $signed(tdata_s));
`else
  assign w_fire = 1'b0;
`endif

  assign w_pass_state = (r_state == c_capture) || w_fire;
  assign w_last       = (r_idx == r_len - c_len_one);
  assign w_hs         = tvalid_m && tready_m;

  // State register: ce=0 freezes everything
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= c_idle;
      r_idx        <= '0;
      r_len        <= '0;
      r_frame_cnt  <= '0;
      r_frame_done <= 1'b0;
`ifdef STREAM_CAPTURE_TRIGGER_EN
      r_prev       <= c_most_neg;
`endif
    end else if (ce) begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_len        <= w_len_nxt;
      r_frame_cnt  <= w_frame_cnt_nxt;
      r_frame_done <= w_frame_done_nxt;
`ifdef STREAM_CAPTURE_TRIGGER_EN
      r_prev       <= w_prev_nxt;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_len_nxt        = r_len;
    w_frame_cnt_nxt  = r_frame_cnt;
    w_frame_done_nxt = 1'b0;
`ifdef STREAM_CAPTURE_TRIGGER_EN
    w_prev_nxt       = r_prev;
`endif
    if (abort_i) begin
      w_state_nxt = c_idle;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (arm_i) begin
            w_len_nxt   = (frame_len_i == '0) ? c_len_one : frame_len_i;
            w_idx_nxt   = '0;
            w_state_nxt = c_arm_state;
`ifdef STREAM_CAPTURE_TRIGGER_EN
            w_prev_nxt  = c_most_neg;
`endif
          end
        end
`ifdef STREAM_CAPTURE_TRIGGER_EN
        c_wait_trig: begin
          if (w_hs) begin
            if (w_last) begin
              w_state_nxt      = c_hold;
              w_idx_nxt        = '0;
              w_frame_cnt_nxt  = r_frame_cnt + 16'd1;
              w_frame_done_nxt = 1'b1;
            end else begin
              w_state_nxt = c_capture;
              w_idx_nxt   = c_len_one;
            end
          end else if (tvalid_s && !w_fire) begin
            w_prev_nxt = tdata_s;
          end
        end
`endif
        c_capture: begin
          if (w_hs) begin
            if (w_last) begin
              w_state_nxt      = c_hold;
              w_idx_nxt        = '0;
              w_frame_cnt_nxt  = r_frame_cnt + 16'd1;
              w_frame_done_nxt = 1'b1;
            end else begin
              w_idx_nxt = r_idx + c_len_one;
            end
          end
        end
        c_hold: begin
          if (release_i) begin
            w_idx_nxt = '0;
            if (continuous_i) begin
              w_state_nxt = c_arm_state;
`ifdef STREAM_CAPTURE_TRIGGER_EN
              w_prev_nxt  = c_most_neg;
`endif
            end else begin
              w_state_nxt = c_idle;
            end
          end
        end
        default: w_state_nxt = c_idle;
      endcase
    end
  end

  // Output logic: zero-latency datapath
  always_comb begin
    tvalid_m = 1'b0;
    tready_s = 1'b1;
    if (!ce) begin
      tready_s = 1'b0;
    end else if (w_pass_state) begin
      tvalid_m = tvalid_s;
      tready_s = tready_m;
    end
    tuser_m = w_pass_state && (r_idx == '0);
    tlast_m = w_pass_state && w_last;
  end

  assign tdata_m      = tdata_s;
  assign busy_o       = (r_state != c_idle);
  assign state_o      = r_state;
  assign frame_done_o = r_frame_done;
  assign frame_cnt_o  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_stream_capture_ctrl.sv
`default_nettype none
// Bench for stream_capture_ctrl: per-cycle behavioural model plus literal checks.
module tb_stream_capture_ctrl;
  localparam int DW = 16;
  localparam int LW = 16;
`ifdef STREAM_CAPTURE_TRIGGER_EN
  localparam bit TRIG = 1'b1;
`else
  localparam bit TRIG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n, ce;
  logic [DW-1:0] tdata_s, tdata_m;
  logic          tvalid_s, tready_s, tvalid_m, tready_m, tuser_m, tlast_m;
  logic [LW-1:0] frame_len_i;
  logic          arm_i, continuous_i, release_i, abort_i;
  logic          busy_o, frame_done_o;
  logic [1:0]    state_o;
  logic [15:0]   frame_cnt_o;
`ifdef STREAM_CAPTURE_TRIGGER_EN
  logic [DW-1:0] trig_level_i;
`endif

  always #5 clk = ~clk;

  stream_capture_ctrl #(.DW(DW), .LW(LW)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce),
    .tdata_s(tdata_s), .tvalid_s(tvalid_s), .tready_s(tready_s),
    .tdata_m(tdata_m), .tvalid_m(tvalid_m), .tready_m(tready_m),
    .tuser_m(tuser_m), .tlast_m(tlast_m),
    .frame_len_i(frame_len_i), .arm_i(arm_i), .continuous_i(continuous_i),
    .release_i(release_i), .abort_i(abort_i),
`ifdef STREAM_CAPTURE_TRIGGER_EN
    .trig_level_i(trig_level_i),
`endif
    .busy_o(busy_o), .state_o(state_o), .frame_done_o(frame_done_o),
    .frame_cnt_o(frame_cnt_o)
  );

  int errors = 0;
  int checks = 0;

  // Model: phase numbers are the externally visible state_o codes
  int m_phase, m_sent, m_len, m_frames, m_prev;
  bit m_done;
  bit take;
  int n_hs = 0, n_user = 0, n_last = 0, n_done = 0;
  logic [DW-1:0] last_hs_data = '0;
  logic [DW-1:0] first_data = '1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic end_frame(output bit nd);
    m_phase  = 3;
    m_sent   = 0;
    m_frames = (m_frames + 1) % 65536;
    nd       = 1'b1;
  endtask

  task automatic model_check();
    bit fire, pass, e_tv, e_trs, e_tu, e_tl, hs, nd;
    logic [DW-1:0] nxt;
    if (!reset_n) begin
      m_phase = 0; m_sent = 0; m_len = 0; m_frames = 0; m_done = 1'b0;
    end
    fire = 1'b0;
`ifdef STREAM_CAPTURE_TRIGGER_EN
    fire = (m_phase == 1) && tvalid_s && (m_prev < int'($signed(trig_level_i))) &&
           (int'($signed(trig_level_i)) <= int'($signed(tdata_s)));
`endif
    pass  = ce && (m_phase == 2 || fire);
    e_tv  = pass && tvalid_s;
    e_trs = !ce ? 1'b0 : (pass ? tready_m : 1'b1);
    e_tu  = (m_phase == 2 && m_sent == 0) || fire;
    e_tl  = (m_phase == 2 || fire) && (m_sent == m_len - 1);
    chk("tvalid_m", tvalid_m, e_tv);
    chk("tready_s", tready_s, e_trs);
    chk("tuser_m", tuser_m, e_tu);
    chk("tlast_m", tlast_m, e_tl);
    chk("tdata_m", tdata_m, tdata_s);
    chk("state_o", state_o, m_phase);
    chk("busy_o", busy_o, m_phase != 0);
    chk("frame_done_o", frame_done_o, m_done);
    chk("frame_cnt_o", frame_cnt_o, m_frames);
    hs   = e_tv && tready_m;
    take = reset_n && tvalid_s && tready_s;
    if (hs) begin
      n_hs++;
      if (e_tu) begin
        n_user++;
        if (first_data == '1) first_data = tdata_m;
      end else begin
        nxt = last_hs_data + 1'b1;
        chk("sample_sequence", tdata_m, nxt);
      end
      if (e_tl) n_last++;
      last_hs_data = tdata_m;
    end
    if (frame_done_o) n_done++;
    if (reset_n && ce) begin
      nd = 1'b0;
      if (abort_i) begin
        m_phase = 0; m_sent = 0;
      end else begin
        case (m_phase)
          0: if (arm_i) begin
               m_len   = (frame_len_i == '0) ? 1 : int'(frame_len_i);
               m_sent  = 0;
               m_prev  = -(1 << (DW - 1));
               m_phase = TRIG ? 1 : 2;
             end
          1: if (hs) begin
               m_sent = 1;
               if (m_sent == m_len) end_frame(nd); else m_phase = 2;
             end else if (tvalid_s && !fire) begin
               m_prev = int'($signed(tdata_s));
             end
          2: if (hs) begin
               m_sent++;
               if (m_sent == m_len) end_frame(nd);
             end
          default: if (release_i) begin
               m_sent = 0;
               if (continuous_i) begin
                 m_phase = TRIG ? 1 : 2;
                 m_prev  = -(1 << (DW - 1));
               end else begin
                 m_phase = 0;
               end
             end
        endcase
      end
      m_done = nd;
    end
  endtask

  // One clock: compare at falling edge, then drive just after rising edge
  task automatic cyc();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    if (take) tdata_s = tdata_s + 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic arm(input int len);
    frame_len_i = LW'(len);
    arm_i = 1'b1;
    cyc();
    arm_i = 1'b0;
  endtask

  task automatic pulse_release();
    release_i = 1'b1;
    cyc();
    release_i = 1'b0;
  endtask

  int b_hs, b_user, b_last, b_done;
  task automatic snap();
    b_hs = n_hs; b_user = n_user; b_last = n_last; b_done = n_done;
  endtask

  initial begin
    reset_n = 1'b0; ce = 1'b1; tdata_s = '0; tvalid_s = 1'b0; tready_m = 1'b1;
    frame_len_i = '0; arm_i = 1'b0; continuous_i = 1'b0; release_i = 1'b0; abort_i = 1'b0;
`ifdef STREAM_CAPTURE_TRIGGER_EN
    trig_level_i = '0;
`endif
    run(2);
    chk("reset_state", state_o, 0);
    chk("reset_tready_s", tready_s, 1);
    chk("reset_frame_cnt", frame_cnt_o, 0);
    reset_n = 1'b1;
    tvalid_s = 1'b1;
    run(2);

    // Single one-shot frame of 8
    arm(8); snap();
    run(12);
    chk("t1_hs", n_hs - b_hs, 8);
    chk("t1_tuser", n_user - b_user, 1);
    chk("t1_tlast", n_last - b_last, 1);
    chk("t1_done", n_done - b_done, 1);
    chk("t1_state", state_o, 3);
    chk("t1_cnt", frame_cnt_o, 1);

    // Continuous re-arm after a long hold
    continuous_i = 1'b1; snap();
    run(20);
    chk("t2_hold_hs", n_hs - b_hs, 0);
    pulse_release(); snap();
    run(12);
    chk("t2_hs", n_hs - b_hs, 8);
    chk("t2_tuser", n_user - b_user, 1);
    chk("t2_cnt", frame_cnt_o, 2);
    continuous_i = 1'b0;
    pulse_release();
    chk("t2_idle", state_o, 0);

    // Back-pressure 1010
    arm(8); snap();
    for (int i = 0; i < 24; i++) begin
      tready_m = (i % 2 == 0);
      cyc();
    end
    tready_m = 1'b1;
    chk("t3_hs", n_hs - b_hs, 8);
    chk("t3_tlast", n_last - b_last, 1);
    chk("t3_cnt", frame_cnt_o, 3);
    pulse_release();

    // Abort at idx 3
    arm(8); snap();
    run(3);
    abort_i = 1'b1;
    cyc();
    abort_i = 1'b0;
    chk("t4_state", state_o, 0);
    chk("t4_tvalid", tvalid_m, 0);
    run(4);
    chk("t4_hs", n_hs - b_hs, 4);
    chk("t4_tlast", n_last - b_last, 0);
    chk("t4_cnt", frame_cnt_o, 3);
    arm_i = 1'b1; abort_i = 1'b1;
    cyc();
    arm_i = 1'b0; abort_i = 1'b0;
    chk("t4_arm_abort", state_o, 0);

    // Length 0 and 1 give single-sample frames
    for (int l = 0; l < 2; l++) begin
      arm(l); snap();
      run(4);
      chk("t5_hs", n_hs - b_hs, 1);
      chk("t5_tuser", n_user - b_user, 1);
      chk("t5_tlast", n_last - b_last, 1);
      chk("t5_state", state_o, 3);
      pulse_release();
    end
    chk("t5_cnt", frame_cnt_o, 5);

    // Clock-enable freeze mid-frame
    arm(4);
    run(2);
    ce = 1'b0;
    run(3);
    ce = 1'b1; snap();
    run(6);
    chk("ce_hs", n_hs - b_hs, 2);
    chk("ce_cnt", frame_cnt_o, 6);
    pulse_release();

    // Asynchronous reset mid-frame
    arm(8); snap();
    run(3);
    reset_n = 1'b0;
    #1;
    chk("rst_state", state_o, 0);
    chk("rst_cnt", frame_cnt_o, 0);
    cyc();
    reset_n = 1'b1;
    run(3);
    chk("rst_tlast", n_last - b_last, 0);

`ifdef STREAM_CAPTURE_TRIGGER_EN
    // Level trigger on a ramp through zero
    tdata_s = 16'hFFFB;
    trig_level_i = '0;
    first_data = '1;
    arm(8); snap();
    run(20);
    chk("t6_first", first_data, 16'h0000);
    chk("t6_hs", n_hs - b_hs, 8);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
